serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 144 ++++++++++++++
 tb/tb_serial_adder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder (LSB first) with a start/busy/done handshake.
// Define OVF_FLAG_EN to add the registered two's-complement overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sha_q, sha_d;
  logic [WIDTH-1:0]   shb_q, shb_d;
  logic [WIDTH-1:0]   shs_q, shs_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef OVF_FLAG_EN
  logic               ovf_q, ovf_d;
`endif

  // The single full-adder cell
  logic s_c;
  logic maj_c;
  assign s_c   = sha_q[0] ^ shb_q[0] ^ carry_q;
  assign maj_c = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shs_d   = shs_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_d  = 1'b1;
        sha_d   = {1'b0, sha_q[WIDTH-1:1]};
        shb_d   = {1'b0, shb_q[WIDTH-1:1]};
        shs_d   = {s_c, shs_q[WIDTH-1:1]};
        carry_d = maj_c;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last edge processes the MSB; carry_q here is the carry into the MSB
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {s_c, shs_q[WIDTH-1:1]};
          cout_d  = maj_c;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef OVF_FLAG_EN
          ovf_d   = carry_q ^ maj_c;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      shs_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shs_q   <= shs_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef OVF_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: timeline/arithmetic model checked every cycle
// plus directed vectors with hand-computed results.
module tb_serial_adder;

  localparam int W  = 8;
  localparam int W1 = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef OVF_FLAG_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  bit chk_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endfunction

  // Model: phase 0 = idle, 1..W = busy cycles, W+1 = done cycle
  int           phase;
  logic [W:0]   pend;
  logic         pend_ovf;
  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    = 0;
      exp_sum  = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        phase    = 1;
        pend     = W1'(a) + W1'(b) + W1'(cin);
        pend_ovf = sovf(a, b, cin);
      end
    end else if (phase < W) begin
      phase = phase + 1;
    end else if (phase == W) begin
      phase = W + 1;
      {exp_cout, exp_sum} = pend;
      exp_ovf = pend_ovf;
    end else begin
      phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(phase >= 1 && phase <= W));
      chk("done", 32'(done), 32'(phase == W + 1));
      chk("sum", 32'(sum), 32'(exp_sum));
      chk("cout", 32'(cout), 32'(exp_cout));
`ifdef OVF_FLAG_EN
      chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    end
  end

  // Starts an operation from an idle negedge and returns on the following idle negedge
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W-1:0] es, input logic ec);
    int  n;
    int  nbusy;
    bit  seen;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    n     = 1;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && n < 25) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) nbusy++;
        @(negedge clk);
        n++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'(W + 1));
    chk("busy_cycles", 32'(nbusy), 32'(W));
    chk("op_sum", 32'(sum), 32'(es));
    chk("op_cout", 32'(cout), 32'(ec));
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 25) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_op(8'h3A, 8'h25, 1'b0, 8'h5F, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op(8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1);

    // Start during RUN must be ignored
    begin
      int nb;
      start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 8'hAA; b = 8'h55;
      @(negedge clk);
      start = 1'b0;
      wait_done("ign_done");
      chk("ign_sum", 32'(sum), 32'h30);
      nb = 0;
      repeat (15) begin
        @(negedge clk);
        if (busy || done) nb++;
      end
      chk("ign_no_second", 32'(nb), 32'd0);
    end

    // Asynchronous reset mid-RUN
    begin
      int nd;
      start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_sum", 32'(sum), 32'd0);
      chk("arst_cout", 32'(cout), 32'd0);
`ifdef OVF_FLAG_EN
      chk("arst_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (15) begin
        @(negedge clk);
        if (done) nd++;
      end
      chk("arst_no_done", 32'(nd), 32'd0);
      run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
    end

    // Back-to-back with start held high
    begin
      int cyc;
      int last;
      int nd;
      cyc = 0; last = -1; nd = 0;
      start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
      while (nd < 3 && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (done) begin
          chk("b2b_sum", 32'(sum), 32'h10);
          if (last >= 0) chk("b2b_period", 32'(cyc - last), 32'(W + 2));
          last = cyc;
          nd++;
        end
      end
      chk("b2b_count", 32'(nd), 32'd3);
      start = 1'b0;
      repeat (W + 3) @(negedge clk);
    end

`ifdef OVF_FLAG_EN
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    chk("ovf_pos", 32'(ovf), 32'd1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    chk("ovf_none", 32'(ovf), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
